// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one conditional add per clock.
// A start accepted in IDLE or DONE loads the operands; WIDTH RUN cycles follow,
// and a one-cycle done pulse marks the new product, which is held until the
// next completion.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    count;

  logic             load;
  logic             step;
  logic             finish;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic [WIDTH-1:0] acc_hi_next;
  logic [WIDTH-1:0] acc_lo_next;

  assign busy = (state == S_RUN);

  // Ripple-carry add of acc_hi and (multiplicand gated by the multiplier LSB).
  always_comb begin : ripple_add
    logic c;
    add_b = acc_lo[0] ? mcand : '0;
    sum   = '0;
    c     = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = acc_hi[i] ^ add_b[i] ^ c;
      c      = (acc_hi[i] & add_b[i]) | (c & (acc_hi[i] ^ add_b[i]));
    end
    carry_out = c;
  end

  // {carry, sum, acc_lo} shifted right one place; carry becomes the new MSB.
  always_comb begin
    acc_hi_next = {carry_out, sum[WIDTH-1:1]};
    acc_lo_next = {sum[0], acc_lo[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: abort beats start, and cancels a run without done.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next = S_IDLE;
        end else begin
          step = 1'b1;
          if (count == LAST) begin
            finish     = 1'b1;
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (start && !abort) begin
          load       = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: operand load, shift-add step, and product capture on the last step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        mcand  <= multiplicand;
        acc_hi <= '0;
        acc_lo <= multiplier;
        count  <= '0;
      end else if (step) begin
        acc_hi <= acc_hi_next;
        acc_lo <= acc_lo_next;
        count  <= count + 1'b1;
      end
      if (finish) begin
        product <= {acc_hi_next, acc_lo_next};
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: stimulus pushes expected products with their due
// cycle into a scoreboard; a negedge monitor checks every done pulse and that
// product holds its last value between completions.
module tb_seq_multiplier;

  localparam int W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [W-1:0]     multiplicand = '0;
  logic [W-1:0]     multiplier = '0;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  typedef struct {
    logic [2*W-1:0] prod;
    int             due;
  } exp_t;

  exp_t           sb[$];
  int             cyc = 0;
  int             n_tests = 0;
  int             n_fail = 0;
  logic [2*W-1:0] last_exp = '0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one cycle; the reference product is plain multiplication.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit ab, input bit accept);
    logic [2*W-1:0] pa;
    logic [2*W-1:0] pb;
    pa = {{W{1'b0}}, a};
    pb = {{W{1'b0}}, b};
    start        = 1'b1;
    abort        = ab;
    multiplicand = a;
    multiplier   = b;
    if (accept) sb.push_back('{prod: pa * pb, due: cyc + W + 1});
    tick();
    start        = 1'b0;
    abort        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Monitor: every done must match the oldest pending product on its due cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", 64'(product), 64'(e.prod));
          check("done_cycle", 64'(cyc), 64'(e.due));
          last_exp = e.prod;
        end
      end else begin
        check("product_hold", 64'(product), 64'(last_exp));
        if (sb.size() != 0 && cyc > sb[0].due) begin
          check("missed_done", 64'd0, 64'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset and idle.
    #1 reset_n = 1'b0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
    end
    tick();

    // Basic multiply with cycle-exact busy/done timing.
    issue(16'd13, 16'd11, 1'b0, 1'b1);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      check("basic_busy", 64'(busy), (c <= 16) ? 64'd1 : 64'd0);
      check("basic_done", 64'(done), (c == 17) ? 64'd1 : 64'd0);
    end
    repeat (13) @(negedge clk);
    check("basic_hold_c30", 64'(product), 64'd143);
    tick();

    // Operand corner cases.
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    wait_drain(40);
    issue(16'h0000, 16'h1234, 1'b0, 1'b1);
    wait_drain(40);
    issue(16'h0001, 16'h8000, 1'b0, 1'b1);
    wait_drain(40);

    // Start while busy is ignored.
    issue(16'd3, 16'd5, 1'b0, 1'b1);
    repeat (4) tick();
    issue(16'd7, 16'd7, 1'b0, 1'b0);
    wait_drain(40);
    tick();

    // Back-to-back: second start lands in the done cycle.
    issue(16'd4, 16'd4, 1'b0, 1'b1);
    repeat (16) tick();
    issue(16'd2, 16'd9, 1'b0, 1'b1);
    wait_drain(40);
    tick();

    // Abort at cycle 8: no done, product keeps the previous result.
    issue(16'd5, 16'd6, 1'b0, 1'b1);
    repeat (7) tick();
    abort = 1'b1;
    void'(sb.pop_back());
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (20) tick();
    check("abort_keep", 64'(product), 64'd18);

    // Start and abort together in IDLE: abort wins.
    issue(16'd9, 16'd9, 1'b1, 1'b0);
    @(negedge clk);
    check("start_abort_busy", 64'(busy), 64'd0);
    tick();

    // Reset in the middle of a run.
    issue(16'd100, 16'd200, 1'b0, 1'b1);
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_product", 64'(product), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    void'(sb.pop_back());
    last_exp = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Randomized runs, mixing back-to-back starts, idle gaps and blocked starts.
    for (int k = 0; k < 40; k++) begin
      bit ab;
      ab = ($urandom_range(0, 7) == 0);
      issue(W'($urandom), W'($urandom), ab, !ab);
      if (!ab) begin
        repeat (W) tick();
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
      end else begin
        tick();
      end
    end
    wait_drain(60);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2000000");
    $fatal(1);
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Multi-cycle unsigned shift-add multiplier for the MiniMips datapath.
- Consumes the ripple add/sub chain built from full_adder cells, one conditional add per cycle.
- Sits downstream of the adder slice and upstream of the HI/LO result registers.
- Single start/done handshake with the control unit; result held until the next accepted start.

Parameters:
- WIDTH, 16, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a multiply; sampled on clk rising edge.
- abort  input  1  synchronous cancel of an operation in progress.
- multiplicand  input  WIDTH  operand A; sampled only on an accepted start.
- multiplier  input  WIDTH  operand B; sampled only on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  2*WIDTH  A*B, unsigned; held stable between completions.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, busy=0, done=0, product=0, internal accumulator/counter=0.
- Internal registers:
  - mcand (WIDTH).
  - acc_hi (WIDTH) plus carry bit.
  - acc_lo (WIDTH), initialised with the multiplier.
  - count, sized clog2(WIDTH) bits.
- States:
  - IDLE: busy=0. start=1 and abort=0 -> load mcand=multiplicand, acc_hi=0, acc_lo=multiplier, count=0; go to RUN.
  - RUN: busy=1. Each edge:
    - if acc_lo[0]=1, {c,sum} = acc_hi + mcand (WIDTH+1 bits, add mode, carry_in 0); else {c,sum} = {0,acc_hi}.
    - {acc_hi,acc_lo} <= {c,sum,acc_lo} >> 1.
    - count <= count+1.
    - On the edge where count==WIDTH-1: write the final shifted value into product, done<=1, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. Next edge goes to IDLE, or reloads and enters RUN if start=1 (back-to-back).
- Latency: start seen in cycle 0 -> busy high in cycles 1..WIDTH -> done pulse in cycle WIDTH+1; product valid from cycle WIDTH+1 onward.
- Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- Product is updated only on completion; it never shows partial values. Operand inputs may change freely after the start edge.
- start while busy (RUN): ignored; operands not resampled; no error flag.
- abort in RUN: next edge -> IDLE, busy=0, no done pulse, product keeps its previous value.
- abort in IDLE/DONE: no effect except that start+abort in the same cycle does not start (abort wins).
- reset_n asserted mid-operation: immediate return to reset values; no done pulse; product cleared to 0.
- Width rule: carry out of the WIDTH-bit add is retained as the MSB shifted in, so no overflow is possible; 2*WIDTH bits always hold the full result.
- Boundary case: count wraps naturally on WIDTH being a power of two; the terminal compare uses WIDTH-1, never wrap detection.

Test Plan:
- Reset then idle, WIDTH=16: reset_n low -> busy=0, done=0, product=0; start=0 for 20 cycles -> outputs unchanged.
- Basic multiply: A=13, B=11, start in cycle 0 -> busy in cycles 1..16, done only in cycle 17, product=143 and still 143 in cycle 30.
- Max operands: A=0xFFFF, B=0xFFFF -> product=0xFFFE0001.
- Zero and one operands:
  - A=0, B=0x1234 -> product=0.
  - A=1, B=0x8000 -> product=0x00008000.
- Start ignored while busy: A=3, B=5 started; at cycle 5 start with A=7, B=7 -> product=15, single done pulse in cycle 17.
- Back-to-back, abort and reset:
  - Back-to-back: start asserted in the done cycle with A=2, B=9 -> second done in cycle 34, product=18.
  - Abort: abort asserted at cycle 8 of a run -> busy=0 next cycle, no done, product retains the prior value.
  - Mid-run reset: reset_n pulsed low at cycle 10 -> product=0, busy=0, done=0 immediately.
